// File: rtl/systolic_skew_feeder.sv
// Skews one accepted matrix row per handshake into the diagonal stream a systolic array
// consumes, then appends zero drain beats after the final row of a batch.
module systolic_skew_feeder #(
  parameter int BitSize     = 8,
  parameter int NumOfInputs = 2,
  parameter int NumOfNerves = 2
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           arr_ready,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_last,
  input  logic [NumOfInputs*BitSize-1:0] s_data,
  output logic [NumOfInputs*BitSize-1:0] m_data,
  output logic                           m_valid,
  output logic                           m_start,
  output logic                           m_last
);

  localparam int DrainLen = NumOfInputs + NumOfNerves - 1;
  localparam int CntW     = $clog2(DrainLen + 1);

  localparam logic [1:0] WAIT   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [CntW-1:0] cnt_reg;
  logic            m_valid_reg;
  logic            m_start_reg;
  logic            m_last_reg;
  logic            accept;
  logic            advance;
  logic            in_drain;

  assign in_drain = (state_reg == DRAIN);
  assign s_ready  = (state_reg == STREAM) && arr_ready;
  assign accept   = s_ready && s_valid;
  assign advance  = accept || in_drain;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT:    if (arr_ready) state_next = STREAM;
      STREAM: begin
        if (!arr_ready)           state_next = WAIT;
        else if (accept && s_last) state_next = DRAIN;
      end
      DRAIN:   if (cnt_reg == CntW'(1)) state_next = arr_ready ? STREAM : WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg   <= WAIT;
      cnt_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_start_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      m_valid_reg <= advance;
      m_start_reg <= accept;
      // The drain beat that takes the counter from 1 to 0 closes the batch.
      m_last_reg  <= in_drain && (cnt_reg == CntW'(1));
      if (accept && s_last)
        cnt_reg <= CntW'(DrainLen);
      else if (in_drain)
        cnt_reg <= cnt_reg - CntW'(1);
    end
  end

  assign m_valid = m_valid_reg;
  assign m_start = m_start_reg;
  assign m_last  = m_last_reg;

  // Lane gi is a gi+1 deep shift register that only moves on an advance.
  for (genvar gi = 0; gi < NumOfInputs; gi++) begin : g_lane
    logic [BitSize-1:0] lane_reg [0:gi];
    logic [BitSize-1:0] lane_in;

    assign lane_in = in_drain ? '0 : s_data[(NumOfInputs-1-gi)*BitSize +: BitSize];

    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        for (int k = 0; k <= gi; k++) lane_reg[k] <= '0;
      end else if (advance) begin
        lane_reg[0] <= lane_in;
        for (int k = 1; k <= gi; k++) lane_reg[k] <= lane_reg[k-1];
      end
    end

    assign m_data[(NumOfInputs-1-gi)*BitSize +: BitSize] = lane_reg[gi];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed scenarios plus random rows, checked against
// a beat-history model where beat k lane j carries element j of the input from beat k-j.
module tb_systolic_skew_feeder;

  localparam int N = 3;
  localparam int P = 2;
  localparam int W = 8;
  localparam int D = N + P - 1;

  logic           clk = 1'b0;
  logic           res_n = 1'b0;
  logic           arr_ready = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic           s_last = 1'b0;
  logic [N*W-1:0] s_data = '0;
  logic [N*W-1:0] m_data;
  logic           m_valid, m_start, m_last;

  logic           b_arr_ready = 1'b0;
  logic           b_valid = 1'b0;
  logic           b_ready;
  logic           b_last = 1'b0;
  logic [W-1:0]   b_data = '0;
  logic [W-1:0]   b_m_data;
  logic           b_m_valid, b_m_start, b_m_last;

  systolic_skew_feeder #(.BitSize(W), .NumOfInputs(N), .NumOfNerves(P)) dut (
    .clk(clk), .res_n(res_n), .arr_ready(arr_ready), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_data(s_data), .m_data(m_data), .m_valid(m_valid),
    .m_start(m_start), .m_last(m_last)
  );

  systolic_skew_feeder #(.BitSize(W), .NumOfInputs(1), .NumOfNerves(3)) dut_b (
    .clk(clk), .res_n(res_n), .arr_ready(b_arr_ready), .s_valid(b_valid), .s_ready(b_ready),
    .s_last(b_last), .s_data(b_data), .m_data(b_m_data), .m_valid(b_m_valid),
    .m_start(b_m_start), .m_last(b_m_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] row;
    logic           start;
    logic           last;
  } beat_t;

  beat_t          hist[$];
  int             beat_idx = 0;
  logic [N*W-1:0] last_data = '0;
  int             n_pass = 0;
  int             n_checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N*W-1:0] expected_lanes(input int k);
    logic [N*W-1:0] e = '0;
    for (int j = 0; j < N; j++)
      if (k - j >= 0 && k - j < hist.size())
        e[(N-1-j)*W +: W] = hist[k-j].row[(N-1-j)*W +: W];
    return e;
  endfunction

  always @(negedge clk or negedge res_n) begin
    if (!res_n) begin
      beat_idx  = 0;
      last_data = '0;
    end else if (m_valid) begin
      if (beat_idx < hist.size()) begin
        chk($sformatf("m_data[%0d]", beat_idx), m_data, expected_lanes(beat_idx));
        chk($sformatf("m_start[%0d]", beat_idx), m_start, hist[beat_idx].start);
        chk($sformatf("m_last[%0d]", beat_idx), m_last, hist[beat_idx].last);
        last_data = expected_lanes(beat_idx);
        $display("beat %0d data=%h start=%0b last=%0b", beat_idx, m_data, m_start, m_last);
      end else begin
        chk("extra_beat", beat_idx, hist.size());
      end
      beat_idx++;
    end else begin
      chk("hold_data", m_data, last_data);
      chk("idle_strobes", {m_start, m_last}, 2'b00);
    end
  end

  // Present a row from a negedge, record it (and its drain beats) in the model on acceptance.
  task automatic send(input logic [N*W-1:0] row, input logic last, input int gap);
    int n = 0;
    s_valid = 1'b1;
    s_data  = row;
    s_last  = last;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1'b1);
    @(posedge clk);
    hist.push_back(beat_t'{row: row, start: 1'b1, last: 1'b0});
    if (last)
      for (int i = 0; i < D; i++)
        hist.push_back(beat_t'{row: '0, start: 1'b0, last: (i == D - 1)});
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain_check();
    for (int i = 0; i < D; i++) begin
      chk($sformatf("s_ready_drain%0d", i), s_ready, 1'b0);
      @(negedge clk);
    end
    chk("s_ready_after_drain", s_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b_exp [4];
    int n;
    res_n       = 1'b0;
    arr_ready   = 1'b1;
    b_arr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_start", m_start, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_b_outs", {b_m_valid, b_m_start, b_m_last, b_m_data}, '0);
    res_n = 1'b1;
    n = 0;
    while (!s_ready && n < 2) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_after_reset", s_ready, 1'b1);

    // N=1, P=3: one row with s_last gives four beats, no skew.
    b_exp = '{8'd5, 8'd0, 8'd0, 8'd0};
    b_valid = 1'b1;
    b_data  = 8'd5;
    b_last  = 1'b1;
    n = 0;
    while (!b_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready", b_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    b_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_valid[%0d]", i), b_m_valid, 1'b1);
      chk($sformatf("b_data[%0d]", i), b_m_data, b_exp[i]);
      chk($sformatf("b_start[%0d]", i), b_m_start, (i == 0));
      chk($sformatf("b_last[%0d]", i), b_m_last, (i == 3));
      $display("b beat %0d data=%h start=%0b last=%0b", i, b_m_data, b_m_start, b_m_last);
      @(negedge clk);
    end
    chk("b_valid_after", b_m_valid, 1'b0);

    // Back-to-back rows, then the same rows with a two-cycle gap.
    send({8'd1, 8'd2, 8'd3}, 1'b0, 0);
    send({8'd4, 8'd5, 8'd6}, 1'b1, 0);
    drain_check();
    send({8'd1, 8'd2, 8'd3}, 1'b0, 2);
    send({8'd4, 8'd5, 8'd6}, 1'b1, 0);
    drain_check();

    // Single row, reset pulsed while drain beat 2 is on the outputs.
    send({8'd7, 8'd8, 8'd9}, 1'b1, 0);
    @(negedge clk);
    #2;
    res_n = 1'b0;
    hist.delete();
    #1;
    chk("async_m_valid", m_valid, 1'b0);
    chk("async_m_data", m_data, '0);
    chk("async_strobes", {m_start, m_last, s_ready}, 3'b000);
    #1;
    res_n = 1'b1;
    @(negedge clk);
    send({8'd1, 8'd1, 8'd1}, 1'b0, 1);

    // Random rows, gaps, batch ends and arr_ready drops.
    for (int r = 0; r < 40; r++) begin
      logic [N*W-1:0] row;
      logic           lst;
      if ($urandom_range(0, 5) == 0) begin
        arr_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        arr_ready = 1'b1;
      end
      row = N*W'($urandom);
      lst = ($urandom_range(0, 3) == 0) || (r == 39);
      send(row, lst, $urandom_range(0, 2));
    end
    repeat (D + 4) @(negedge clk);
    chk("beat_count", beat_idx, hist.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Transmit-side companion of `systolic_array`. Accepts one full row of matrix A per handshake and emits the diagonally skewed stream the array consumes: element j of a row is delayed by j valid beats, plus start and valid strobes.
- After the last row of a batch, appends zero-filled drain beats so every result column exits the array.
- Sits between the row source (buffer or previous layer) and the array's in_data/in_start/in_valid.

Parameters:
- BitSize, 8: width of one data element.
- NumOfInputs, 2: elements per row (n); must equal the array's NumOfInputs; ≥1.
- NumOfNerves, 2: array column count (p); sets drain length; ≥1.

Ports:
- clk, input, 1: clock, all logic on posedge.
- res_n, input, 1: asynchronous active-low reset.
- arr_ready, input, 1: array's out_ready (weights loaded).
- s_valid, input, 1: row source has a row.
- s_ready, output, 1: feeder accepts a row this cycle.
- s_last, input, 1: accompanying row is the final row of the batch.
- s_data, input, NumOfInputs*BitSize: row; element j at bits [(NumOfInputs-1-j)*BitSize +: BitSize], so element 0 is the MSB slice.
- m_data, output, NumOfInputs*BitSize: skewed lanes to array in_data; same slice-per-element mapping.
- m_valid, output, 1: to array in_valid; one beat per cycle high.
- m_start, output, 1: to array in_start; marks the beat carrying a new row's element 0.
- m_last, output, 1: high on the final drain beat of a batch.

Behaviour:
- Reset (async, any time, incl. mid-stream or mid-drain):
  - m_valid, m_start, m_last = 0; m_data = 0; all lane delay registers = 0.
  - drain counter = 0; state = WAIT.
- States:
  - WAIT: s_ready=0, no beats. Go to STREAM when arr_ready=1 (registered).
  - STREAM: s_ready = arr_ready.
  - DRAIN: s_ready=0.
- Advance event: (STREAM and s_valid and s_ready) or (DRAIN). Only on an advance:
  - every lane shift register moves one stage;
  - lane j has j+1 register stages; its input is element j of s_data (zero in DRAIN);
  - m_data lane j = last stage of lane j.
- m_valid is registered and equals advance of the previous cycle, giving exactly one m_valid beat per advance.
- m_start is registered: 1 on the beat produced by a row acceptance, 0 on drain beats.
- No advance means m_valid=0 and all lanes hold; the array freezes on in_valid=0, so gaps are legal anywhere.
- Latency: row accepted in cycle t → element 0 on m_data in cycle t+1. Element j appears on the j-th subsequent m_valid beat.
- s_last accepted in STREAM → DRAIN next cycle with drain counter loaded to D = NumOfInputs+NumOfNerves-1.
  - Each drain beat decrements the counter.
  - The beat where the counter goes 1→0 has m_last=1; state then returns to STREAM (or WAIT if arr_ready=0).
- arr_ready dropping in STREAM → WAIT; lane contents are preserved.
- Drain counter width: $clog2(D+1); no wrap, loaded only on s_last acceptance.
- NumOfInputs=1: single lane with 1 stage, no skew.
- m_data lanes are never driven with X; unused lane positions carry zeros.

Test Plan:
- Notation: N=NumOfInputs, P=NumOfNerves; lane tuples are (e0,e1,e2).
- Reset held, arr_ready=1 → s_ready=0, m_valid=m_start=m_last=0, m_data=0. Release res_n → s_ready=1 within 2 cycles.
- N=3, P=2, D=4. Back-to-back rows (1,2,3) then (4,5,6) with s_last:
  - beat 1: (1,0,0), start; beat 2: (4,2,0), start;
  - beats 3–6: (0,5,3), (0,0,6), (0,0,0), (0,0,0); beat 6 m_last=1;
  - s_ready=0 during beats 3–6.
- Same rows with a 2-cycle s_valid gap between them → m_valid low for exactly 2 cycles, lane values held, same beat sequence.
- Single row (7,8,9) with s_last → 5 beats: (7,0,0) start, (0,8,0), (0,0,9), (0,0,0), (0,0,0) last.
- res_n pulsed low during drain beat 2 → all outputs 0 asynchronously. After release, a new row (1,1,1) yields beat (1,0,0) with no stale data.
- N=1, P=3: row (5) with s_last → beats (5) start, 0, 0, 0 last (D=3).
